// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: received byte, valid/ack handshake and error flags.
// No latency of its own; the consumer holds off the receiver only by leaving rx_ack low, which raises overrun.
interface uart_rx_if;
  logic [7:0] d_out;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output d_out, rx_valid, frame_err, parity_err, overrun,
    input  rx_ack
  );

  modport slave (
    input  d_out, rx_valid, frame_err, parity_err, overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver on a 16x baud_tick; even-parity slot added when UART_RX_PARITY_EN is defined.
// Latency: 2 clk rxd synchroniser; rx_valid rises 1 clk after the baud_tick that samples the stop bit.
// Backpressure: none on the line; a byte completing over an unacknowledged one overwrites it and sets overrun.
module uart_rx #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      baud_tick,
  input  logic      enable_rx,
  input  logic      rxd,
  output logic      receiving,
  uart_rx_if.master rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic          rxd_m, rxd_s;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          armed;
  logic          bit_end;

  assign bit_end = (tick_cnt == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m             <= 1'b1;
      rxd_s             <= 1'b1;
      state             <= IDLE;
      tick_cnt          <= '0;
      bit_cnt           <= '0;
      shift_q           <= '0;
      armed             <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q             <= 1'b0;
`endif
      receiving         <= 1'b0;
      rx_bus.d_out      <= '0;
      rx_bus.rx_valid   <= 1'b0;
      rx_bus.frame_err  <= 1'b0;
      rx_bus.parity_err <= 1'b0;
      rx_bus.overrun    <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      if (!enable_rx) begin
        state             <= IDLE;
        tick_cnt          <= '0;
        bit_cnt           <= '0;
        armed             <= 1'b1;
        receiving         <= 1'b0;
        rx_bus.d_out      <= '0;
        rx_bus.rx_valid   <= 1'b0;
        rx_bus.frame_err  <= 1'b0;
        rx_bus.parity_err <= 1'b0;
        rx_bus.overrun    <= 1'b0;
      end else begin
        if (rx_bus.rx_valid && rx_bus.rx_ack) begin
          rx_bus.rx_valid <= 1'b0;
          rx_bus.overrun  <= 1'b0;
        end
        // Completion assignments below come last so they win over a same-cycle ack.
        if (baud_tick) begin
          case (state)
            IDLE: begin
              if (!rxd_s && armed) begin
                state     <= START;
                tick_cnt  <= '0;
                receiving <= 1'b1;
              end else if (rxd_s) begin
                armed <= 1'b1;
              end
            end
            START: begin
              if (tick_cnt == TW'(SAMPLE_POINT)) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                if (rxd_s) begin
                  state     <= IDLE;
                  receiving <= 1'b0;
                end else begin
                  state <= DATA;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
            DATA: begin
              if (bit_end) begin
                tick_cnt <= '0;
                shift_q  <= {rxd_s, shift_q[7:1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state <= PARITY;
`else
                  state <= STOP;
`endif
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
              if (bit_end) begin
                tick_cnt <= '0;
                par_q    <= rxd_s;
                state    <= STOP;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
`endif
            STOP: begin
              if (bit_end) begin
                tick_cnt         <= '0;
                state            <= IDLE;
                receiving        <= 1'b0;
                // A low stop bit (break) must see the line high again before the next start.
                armed            <= rxd_s;
                rx_bus.d_out     <= shift_q;
                rx_bus.frame_err <= ~rxd_s;
`ifdef UART_RX_PARITY_EN
                rx_bus.parity_err <= (^shift_q) ^ par_q;
`else
                rx_bus.parity_err <= 1'b0;
`endif
                rx_bus.rx_valid  <= 1'b1;
                rx_bus.overrun   <= rx_bus.rx_valid && !rx_bus.rx_ack;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with 16x oversampling and baud_tick every 4 clk.
// Latency: each bit is held 64 clk; results are sampled 1 time unit after a rising clk edge.
// Backpressure: rx_ack is pulsed by the bench; overrun is provoked by withholding it.
module tb_uart_rx;
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic baud_tick = 1'b0;
  logic enable_rx = 1'b1;
  logic rxd       = 1'b1;
  logic receiving;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   tick_ph   = 0;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(16), .SAMPLE_POINT(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .enable_rx (enable_rx),
    .rxd       (rxd),
    .receiving (receiving),
    .rx_bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (tick_ph == 3);
      tick_ph   = (tick_ph + 1) % 4;
    end
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    clks(64);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    clks(1);
    bus.rx_ack = 1'b0;
  endtask

  // Start, data and (optional) parity, then the stop level; returns once the frame completes.
  task automatic rx_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    chk1("recv_mid", receiving, 1'b1);
    rxd = stop;
    for (int k = 0; k < 200 && receiving; k++) clks(1);
    chk1("frame_done", ~receiving, 1'b1);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    clks(n);
  endtask

  initial begin
    bus.rx_ack = 1'b0;
    clks(3);
    chk8("rst_d_out", bus.d_out, 8'h00);
    chk1("rst_valid", bus.rx_valid, 1'b0);
    chk1("rst_recv", receiving, 1'b0);
    chk1("rst_ferr", bus.frame_err, 1'b0);
    chk1("rst_perr", bus.parity_err, 1'b0);
    chk1("rst_ovr", bus.overrun, 1'b0);
    rst_n = 1'b1;
    idle(100);

    // Clean 0xA5: receiving falls on the same edge rx_valid rises.
    rx_frame(8'hA5, ^8'hA5, 1'b1);
    chk1("a5_valid", bus.rx_valid, 1'b1);
    chk8("a5_d_out", bus.d_out, 8'hA5);
    chk1("a5_ferr", bus.frame_err, 1'b0);
    chk1("a5_perr", bus.parity_err, 1'b0);
    chk1("a5_ovr", bus.overrun, 1'b0);
    idle(64);
    ack();
    chk1("a5_ack_valid", bus.rx_valid, 1'b0);
    ack();
    chk1("idle_ack_valid", bus.rx_valid, 1'b0);
    chk1("idle_ack_ovr", bus.overrun, 1'b0);

    // False start: 5 ticks low.
    rxd = 1'b0;
    clks(20);
    rxd = 1'b1;
    chk1("fs_recv_hi", receiving, 1'b1);
    clks(60);
    chk1("fs_recv_lo", receiving, 1'b0);
    chk1("fs_valid", bus.rx_valid, 1'b0);
    idle(64);

    // Framing error, then recovery.
    rx_frame(8'h3C, ^8'h3C, 1'b0);
    chk8("3c_d_out", bus.d_out, 8'h3C);
    chk1("3c_ferr", bus.frame_err, 1'b1);
    chk1("3c_valid", bus.rx_valid, 1'b1);
    ack();
    chk1("3c_ferr_sticky", bus.frame_err, 1'b1);
    idle(128);
    rx_frame(8'h01, ^8'h01, 1'b1);
    chk8("01_d_out", bus.d_out, 8'h01);
    chk1("01_ferr", bus.frame_err, 1'b0);
    ack();
    idle(64);

    // Overrun.
    rx_frame(8'h11, ^8'h11, 1'b1);
    chk1("11_ovr", bus.overrun, 1'b0);
    idle(64);
    rx_frame(8'h22, ^8'h22, 1'b1);
    chk8("22_d_out", bus.d_out, 8'h22);
    chk1("22_ovr", bus.overrun, 1'b1);
    chk1("22_valid", bus.rx_valid, 1'b1);
    ack();
    chk1("22_ack_valid", bus.rx_valid, 1'b0);
    chk1("22_ack_ovr", bus.overrun, 1'b0);
    idle(64);

`ifdef UART_RX_PARITY_EN
    rx_frame(8'h07, 1'b0, 1'b1);
    chk1("07_bad_perr", bus.parity_err, 1'b1);
    ack();
    idle(64);
    rx_frame(8'h07, 1'b1, 1'b1);
    chk1("07_good_perr", bus.parity_err, 1'b0);
    ack();
    idle(64);
`endif

    // Break: line held low.
    rx_frame(8'h00, 1'b0, 1'b0);
    chk8("brk_d_out", bus.d_out, 8'h00);
    chk1("brk_ferr", bus.frame_err, 1'b1);
    ack();
    clks(300);
    chk1("brk_no_rearm_recv", receiving, 1'b0);
    chk1("brk_no_rearm_valid", bus.rx_valid, 1'b0);
    idle(128);

    // Reset at data bit 4 of 0xFF, with an unacknowledged byte pending.
    rx_frame(8'h5A, ^8'h5A, 1'b1);
    chk8("5a_d_out", bus.d_out, 8'h5A);
    idle(64);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clks(32);
    chk1("rstmid_recv_before", receiving, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rstmid_valid", bus.rx_valid, 1'b0);
    chk8("rstmid_d_out", bus.d_out, 8'h00);
    chk1("rstmid_recv", receiving, 1'b0);
    clks(2);
    rst_n = 1'b1;
    idle(704);
    rx_frame(8'h55, ^8'h55, 1'b1);
    chk8("55a_d_out", bus.d_out, 8'h55);
    chk1("55a_ferr", bus.frame_err, 1'b0);
    idle(64);

    // enable_rx drop at data bit 4 of 0xFF; 0x55 left unacknowledged.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clks(32);
    enable_rx = 1'b0;
    clks(1);
    chk1("en_valid", bus.rx_valid, 1'b0);
    chk8("en_d_out", bus.d_out, 8'h00);
    chk1("en_recv", receiving, 1'b0);
    enable_rx = 1'b1;
    idle(704);
    rx_frame(8'h55, ^8'h55, 1'b1);
    chk8("55b_d_out", bus.d_out, 8'h55);
    chk1("55b_valid", bus.rx_valid, 1'b1);
    chk1("55b_ovr", bus.overrun, 1'b0);
    ack();
    idle(32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the UART transmit stage and consumes its `txd` line.
- Recovers 8-bit frames from an asynchronous line using a 16x oversampling tick.
- Presents each received byte on a parallel output with a valid/ack handshake, to the register controller or a display.
- Flags framing, parity and overrun errors.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; power of two, 8..16.
- SAMPLE_POINT, 7, tick index within a bit at which the line is sampled (mid-bit).

Ports:
- clk  input  1  general clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate
- enable_rx  input  1  module enable; low forces idle
- rxd  input  1  serial line, idle high, asynchronous to clk
- rx_ack  input  1  consumer has taken d_out; one-clk pulse or level
- d_out  output  8  last received byte
- rx_valid  output  1  d_out holds an unacknowledged byte
- receiving  output  1  frame in progress (LED indicator)
- frame_err  output  1  stop bit of last frame sampled low
- parity_err  output  1  parity check of last frame failed
- overrun  output  1  byte completed while rx_valid was still set

Behaviour:
- Reset (rst_n low, asynchronous):
  - d_out = 0; rx_valid, receiving, frame_err, parity_err, overrun = 0.
  - Synchroniser flops = 1; state = IDLE; tick and bit counters = 0.
- rxd passes through a 2-flop synchroniser (rxd_s) before any use. Adds 2 clk of latency.
- State and counter transitions occur only on clk edges with baud_tick=1. Handshake logic runs every clk.
- States:
  - IDLE:
    - On rxd_s=0 at a tick: go to START, tick_cnt=0, receiving=1.
  - START:
    - At tick_cnt==SAMPLE_POINT, rxd_s=1: false start; return to IDLE, receiving=0, no flags change.
    - At tick_cnt==SAMPLE_POINT, rxd_s=0: tick_cnt=0, bit_cnt=0, go to DATA.
  - DATA:
    - Each time tick_cnt reaches OVERSAMPLE-1, sample rxd_s into the shift register, LSB first, and set tick_cnt=0.
    - After bit_cnt==7 is sampled, go to PARITY (macro defined) or STOP.
  - PARITY:
    - After OVERSAMPLE ticks, sample the parity bit, then go to STOP.
  - STOP:
    - After OVERSAMPLE ticks, sample the stop bit.
    - d_out <= shift register; frame_err <= ~rxd_s; parity_err per the optional feature.
    - rx_valid <= 1; receiving <= 0; go to IDLE.
    - The byte is delivered even if frame_err is set.
- Handshake:
  - rx_valid stays high until a clk with rx_ack=1, which clears it next edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun:
  - If a frame completes while rx_valid=1 and rx_ack=0: overrun <= 1 and d_out is overwritten with the new byte.
  - overrun clears together with rx_valid on rx_ack.
- Simultaneous frame completion and rx_ack:
  - The completion wins: rx_valid stays 1, d_out takes the new byte, overrun is not set.
- frame_err and parity_err describe the most recent frame only. They are rewritten at every completion and are not cleared by rx_ack.
- enable_rx low (synchronous, any state):
  - State returns to IDLE; receiving, rx_valid, overrun, frame_err, parity_err = 0; d_out = 0.
  - A mid-frame byte is discarded.
- Reset mid-frame: partial byte discarded, all outputs go to reset values immediately.
- Receive latency: rx_valid rises 1 clk after the baud_tick at which the stop bit is sampled.
- A line held low (break):
  - The frame completes with frame_err=1 and d_out=0x00.
  - The receiver then re-arms only after rxd_s has been seen high in IDLE. IDLE requires one high tick before accepting a new start edge after a frame_err.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is start, d0..d7, parity, stop (11-bit-period-compatible with the transmitter's parity slot).
  - parity_err <= (^data) ^ parity_bit, i.e. even parity.
- Undefined:
  - Frame is 8N1; the PARITY state is not generated.
  - parity_err is constantly 0.

Test Plan:
1. OVERSAMPLE=16, baud_tick every 4 clk. Send 0xA5 with correct stop (and parity 0 if enabled) -> d_out=0xA5, rx_valid=1, frame_err=0, parity_err=0, receiving falls with rx_valid rise.
2. Pulse rxd low for 5 ticks only -> false start; rx_valid stays 0, state back to IDLE, receiving high for at most 8 ticks.
3. Send 0x3C with stop bit 0 -> d_out=0x3C, frame_err=1. Then idle high and send 0x01 -> frame_err=0.
4. Send 0x11 without rx_ack, then 0x22 -> d_out=0x22, overrun=1. rx_ack pulse -> rx_valid=0, overrun=0.
5. With UART_RX_PARITY_EN, send 0x07 (three ones) with parity bit 0 -> parity_err=1; same byte with parity 1 -> parity_err=0.
6. Drop rst_n, and separately enable_rx, at data bit 4 of 0xFF -> outputs return to 0 immediately/next clk. Next clean frame 0x55 received correctly.
